// File: rtl/fmc_i2c_pkg.sv
// ============================================================================
// Module      : fmc_i2c_pkg
// Description : Shared constants and the one-hot state type for the FMC I2C
//               write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fmc_i2c_pkg;

    localparam int S_IDLE    = 0;
    localparam int S_ISSUE   = 1;
    localparam int S_WAIT    = 2;
    localparam int S_RELEASE = 3;
    localparam int N_STATES  = 4;

    localparam int          I2C_BYTE_W        = 8;
    localparam int unsigned TO_CYCLES_DEFAULT = 1_250_000;

    typedef enum logic [N_STATES-1:0] {
        ST_IDLE    = N_STATES'(1 << S_IDLE),
        ST_ISSUE   = N_STATES'(1 << S_ISSUE),
        ST_WAIT    = N_STATES'(1 << S_WAIT),
        ST_RELEASE = N_STATES'(1 << S_RELEASE)
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_write_arbiter_if.sv
// ============================================================================
// Module      : i2c_write_arbiter_if
// Description : Requester and byte-write-engine signals of the I2C arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_write_arbiter_if #(
    parameter int NREQ = 3
);
    import fmc_i2c_pkg::*;

    logic [NREQ-1:0]            req;
    logic [I2C_BYTE_W*NREQ-1:0] req_dev_adr;
    logic [I2C_BYTE_W*NREQ-1:0] req_reg_dat;
    logic                       i2c_wr_done;
    logic [I2C_BYTE_W-1:0]      i2c_dev_adr;
    logic [I2C_BYTE_W-1:0]      i2c_reg_dat;
    logic                       i2c_start_write;
    logic [NREQ-1:0]            grant;
    logic [NREQ-1:0]            done;
    logic                       busy;
    logic                       err_timeout;

    // The arbiter side
    modport master (
        input  req, req_dev_adr, req_reg_dat, i2c_wr_done,
        output i2c_dev_adr, i2c_reg_dat, i2c_start_write,
        output grant, done, busy, err_timeout
    );

    // Requesters plus engine
    modport slave (
        output req, req_dev_adr, req_reg_dat, i2c_wr_done,
        input  i2c_dev_adr, i2c_reg_dat, i2c_start_write,
        input  grant, done, busy, err_timeout
    );

endinterface

`default_nettype wire

// File: rtl/rr_pick_onehot.sv
// ============================================================================
// Module      : rr_pick_onehot
// Description : Combinational rotate-priority encoder; the search starts one
//               position above last_idx_i and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick_onehot #(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_idx_i,
    output logic [NREQ-1:0]  onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    localparam int             C_PW = IDX_W + 1;
    localparam logic [C_PW-1:0] C_N = C_PW'(NREQ);

    logic [C_PW-1:0] pos;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        pos      = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = {1'b0, last_idx_i} + C_PW'(i + 1);
            if (pos >= C_N) begin
                pos = pos - C_N;
            end
            if (!any_o && req_i[pos[IDX_W-1:0]]) begin
                any_o                     = 1'b1;
                idx_o                     = pos[IDX_W-1:0];
                onehot_o[pos[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_write_arbiter.sv
// ============================================================================
// Module      : i2c_write_arbiter
// Description : Round-robin owner of the single FMC I2C byte-write engine.
//               Optional watchdog in WAIT: define I2C_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_write_arbiter
    import fmc_i2c_pkg::*;
#(
    parameter int          NREQ      = 3,
    parameter int unsigned TO_CYCLES = TO_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    i2c_write_arbiter_if.master bus_io
);
    localparam int C_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    generate
        if (NREQ < 2 || NREQ > 8 || TO_CYCLES == 0) begin : g_bad_param
            $error("i2c_write_arbiter: NREQ must be 2..8 and TO_CYCLES nonzero");
        end
    endgenerate

    state_t                state_q, state_d;
    logic [NREQ-1:0]       grant_q, grant_d;
    logic [NREQ-1:0]       done_q, done_d;
    logic                  start_q, start_d;
    logic [I2C_BYTE_W-1:0] adr_q, adr_d;
    logic [I2C_BYTE_W-1:0] dat_q, dat_d;
    logic [C_IDX_W-1:0]    rr_last_q, rr_last_d;

    logic [NREQ-1:0]       pick_onehot;
    logic [C_IDX_W-1:0]    pick_idx;
    logic                  pick_any;
    logic [I2C_BYTE_W-1:0] pick_adr, pick_dat;
    logic                  wait_expired;

    rr_pick_onehot #(
        .NREQ  (NREQ),
        .IDX_W (C_IDX_W)
    ) u_pick (
        .req_i      (bus_io.req),
        .last_idx_i (rr_last_q),
        .onehot_o   (pick_onehot),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    always_comb begin
        pick_adr = '0;
        pick_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) begin
                pick_adr = pick_adr | bus_io.req_dev_adr[i*I2C_BYTE_W +: I2C_BYTE_W];
                pick_dat = pick_dat | bus_io.req_reg_dat[i*I2C_BYTE_W +: I2C_BYTE_W];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(TO_CYCLES + 1);

    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               err_q, err_d;

    // Counter reads 0 on the first WAIT cycle, so TO_CYCLES-1 is the last one
    assign wait_expired = (state_q == ST_WAIT) && (cnt_q == C_CNT_W'(TO_CYCLES - 1));
    assign err_d        = wait_expired && !bus_io.i2c_wr_done;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            cnt_d = cnt_q + C_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus_io.err_timeout = err_q;
`else
    assign wait_expired       = 1'b0;
    assign bus_io.err_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        start_d   = start_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d   = ST_ISSUE;
                    grant_d   = pick_onehot;
                    rr_last_d = pick_idx;
                    adr_d     = pick_adr;
                    dat_d     = pick_dat;
                    start_d   = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus_io.i2c_wr_done || wait_expired) begin
                    state_d = ST_RELEASE;
                    done_d  = grant_q;
                    grant_d = '0;
                    start_d = 1'b0;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            start_q   <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            rr_last_q <= C_IDX_W'(NREQ - 1);
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            start_q   <= start_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign bus_io.grant           = grant_q;
    assign bus_io.done            = done_q;
    assign bus_io.i2c_start_write = start_q;
    assign bus_io.i2c_dev_adr     = adr_q;
    assign bus_io.i2c_reg_dat     = dat_q;
    assign bus_io.busy            = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_i2c_write_arbiter.sv
// ============================================================================
// Module      : tb_i2c_write_arbiter
// Description : Directed and randomized bench for i2c_write_arbiter against a
//               cycle-stamped transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_write_arbiter;
    import fmc_i2c_pkg::*;

    localparam int NREQ = 3;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned TO = 50;
`else
    localparam int unsigned TO = TO_CYCLES_DEFAULT;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #4 clk = ~clk;

    i2c_write_arbiter_if #(.NREQ(NREQ)) bus();

    i2c_write_arbiter #(
        .NREQ      (NREQ),
        .TO_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int onehot2idx(input logic [NREQ-1:0] v);
        onehot2idx = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) onehot2idx = i;
    endfunction

    // Model: a transfer is a record (owner, issue cycle, latched adr/dat);
    // the engine is free again from the cycle after the done pulse.
    int              cyc       = 0;
    int              own       = -1;
    int              last      = NREQ - 1;
    int              issued    = 0;
    int              idle_from = 0;
    logic [7:0]      m_adr     = '0;
    logic [7:0]      m_dat     = '0;
    logic [NREQ-1:0] m_done    = '0;
    logic            m_err     = 1'b0;
    int              m_done_cnt = 0;
    int              dut_done_cnt [NREQ];
    bit              cmp_en    = 1'b0;

    initial for (int i = 0; i < NREQ; i++) dut_done_cnt[i] = 0;

    always @(posedge clk) begin
        cyc++;
        m_done = '0;
        m_err  = 1'b0;
        if (reset) begin
            own       = -1;
            last      = NREQ - 1;
            idle_from = cyc;
        end else if (own >= 0) begin
            if (bus.i2c_wr_done && (cyc - 1 > issued)) begin
                m_done[own] = 1'b1;
                own         = -1;
                idle_from   = cyc + 1;
                m_done_cnt++;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (cyc == issued + 1 + int'(TO)) begin
                m_done[own] = 1'b1;
                m_err       = 1'b1;
                own         = -1;
                idle_from   = cyc + 1;
                m_done_cnt++;
            end
`endif
        end else if ((cyc - 1 >= idle_from) && (bus.req != '0)) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (own < 0 && bus.req[(last + k) % NREQ]) own = (last + k) % NREQ;
            end
            last   = own;
            issued = cyc;
            m_adr  = bus.req_dev_adr[8*own +: 8];
            m_dat  = bus.req_reg_dat[8*own +: 8];
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        if (cmp_en) begin
            eg = '0;
            if (own >= 0) eg[own] = 1'b1;
            chk("grant", bus.grant, eg);
            chk("start_write", bus.i2c_start_write, own >= 0);
            chk("busy", bus.busy, (own >= 0) || (cyc < idle_from));
            chk("done", bus.done, m_done);
            chk("err_timeout", bus.err_timeout, m_err);
            if (own >= 0) begin
                chk("dev_adr", bus.i2c_dev_adr, m_adr);
                chk("reg_dat", bus.i2c_reg_dat, m_dat);
            end
            for (int i = 0; i < NREQ; i++) if (bus.done[i]) dut_done_cnt[i]++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b1;
        bus.req         = '0;
        bus.i2c_wr_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int exp3 [6] = '{0, 1, 2, 0, 1, 2};
    int tot;

    initial begin
        bus.req         = '0;
        bus.req_dev_adr = '0;
        bus.req_reg_dat = '0;
        bus.i2c_wr_done = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_start", bus.i2c_start_write, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_adr", bus.i2c_dev_adr, 0);
        reset = 1'b0;

        // 1: single request, engine finishes ten cycles later
        bus.req_dev_adr[7:0] = 8'hEA;
        bus.req_reg_dat[7:0] = 8'h04;
        bus.req              = 3'b001;
        @(negedge clk);
        chk("t1_start", bus.i2c_start_write, 1);
        chk("t1_grant", bus.grant, 3'b001);
        chk("t1_adr", bus.i2c_dev_adr, 8'hEA);
        chk("t1_dat", bus.i2c_reg_dat, 8'h04);
        repeat (9) @(negedge clk);
        bus.i2c_wr_done = 1'b1;
        @(negedge clk);
        bus.i2c_wr_done = 1'b0;
        chk("t1_done", bus.done, 3'b001);
        bus.req = '0;
        @(negedge clk);
        chk("t1_busy_after", bus.busy, 0);

        // 2: two requests held across reset
        @(negedge clk);
        reset                 = 1'b1;
        bus.req_dev_adr[15:0] = 16'h3311;
        bus.req_reg_dat[15:0] = 16'h4422;
        bus.req               = 3'b011;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t2_grant0", bus.grant, 3'b001);
        chk("t2_adr0", bus.i2c_dev_adr, 8'h11);
        repeat (2) @(negedge clk);
        bus.i2c_wr_done = 1'b1;
        @(negedge clk);
        bus.i2c_wr_done = 1'b0;
        chk("t2_done0", bus.done, 3'b001);
        bus.req = 3'b010;
        @(negedge clk);
        chk("t2_gap", bus.grant, 3'b000);
        @(negedge clk);
        chk("t2_grant1", bus.grant, 3'b010);
        chk("t2_adr1", bus.i2c_dev_adr, 8'h33);
        chk("t2_dat1", bus.i2c_reg_dat, 8'h44);
        repeat (2) @(negedge clk);
        bus.i2c_wr_done = 1'b1;
        @(negedge clk);
        bus.i2c_wr_done = 1'b0;
        chk("t2_done1", bus.done, 3'b010);
        bus.req = '0;

        // 3: all three held for six transfers
        @(negedge clk);
        reset   = 1'b1;
        bus.req = 3'b111;
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("t3_order", onehot2idx(bus.grant), exp3[t]);
            @(negedge clk);
            bus.i2c_wr_done = 1'b1;
            @(negedge clk);
            bus.i2c_wr_done = 1'b0;
            @(negedge clk);
        end
        bus.req = '0;

        // 4: stray wr_done in IDLE and in ISSUE
        do_reset();
        bus.i2c_wr_done = 1'b1;
        @(negedge clk);
        bus.i2c_wr_done = 1'b0;
        chk("t4_idle_done", bus.done, 0);
        chk("t4_idle_busy", bus.busy, 0);
        bus.req = 3'b001;
        @(negedge clk);
        chk("t4_issue_grant", bus.grant, 3'b001);
        bus.i2c_wr_done = 1'b1;
        @(negedge clk);
        bus.i2c_wr_done = 1'b0;
        chk("t4_issue_done", bus.done, 0);
        chk("t4_issue_start", bus.i2c_start_write, 1);
        @(negedge clk);
        bus.i2c_wr_done = 1'b1;
        @(negedge clk);
        bus.i2c_wr_done = 1'b0;
        chk("t4_real_done", bus.done, 3'b001);
        bus.req = '0;

        // 5: reset while waiting on the engine
        do_reset();
        bus.req = 3'b001;
        repeat (3) @(negedge clk);
        reset           = 1'b1;
        bus.req         = '0;
        bus.i2c_wr_done = 1'b1;
        @(negedge clk);
        chk("t5_grant", bus.grant, 0);
        chk("t5_done", bus.done, 0);
        chk("t5_start", bus.i2c_start_write, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_adr", bus.i2c_dev_adr, 0);
        chk("t5_dat", bus.i2c_reg_dat, 0);
        reset                  = 1'b0;
        bus.i2c_wr_done        = 1'b0;
        bus.req_dev_adr[23:16] = 8'h5A;
        bus.req_reg_dat[23:16] = 8'hC3;
        bus.req                = 3'b100;
        @(negedge clk);
        chk("t5_grant2", bus.grant, 3'b100);
        chk("t5_adr2", bus.i2c_dev_adr, 8'h5A);
        @(negedge clk);
        bus.i2c_wr_done = 1'b1;
        @(negedge clk);
        bus.i2c_wr_done = 1'b0;
        chk("t5_done2", bus.done, 3'b100);
        bus.req = '0;

`ifdef I2C_ARB_TIMEOUT_EN
        // 6: engine never answers
        do_reset();
        bus.req = 3'b010;
        @(negedge clk);
        chk("t6_grant", bus.grant, 3'b010);
        repeat (50) @(negedge clk);
        chk("t6_no_early", bus.done, 0);
        @(negedge clk);
        chk("t6_done", bus.done, 3'b010);
        chk("t6_err", bus.err_timeout, 1);
        bus.req = '0;
        repeat (2) @(negedge clk);
        chk("t6_busy", bus.busy, 0);
`endif

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(5) == 0) begin
                        bus.req[i]                = 1'b1;
                        bus.req_dev_adr[8*i +: 8] = 8'($urandom);
                        bus.req_reg_dat[8*i +: 8] = 8'($urandom);
                    end
                end else if (bus.done[i]) begin
                    if ($urandom_range(3) != 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(59) == 0) begin
                    bus.req[i] = 1'b0;
                end
                if ($urandom_range(9) == 0) bus.req_dev_adr[8*i +: 8] = 8'($urandom);
                if ($urandom_range(9) == 0) bus.req_reg_dat[8*i +: 8] = 8'($urandom);
            end
            bus.i2c_wr_done = ($urandom_range(7) == 0);
        end
        bus.req = '0;
        repeat (20) begin
            @(negedge clk);
            bus.i2c_wr_done = ($urandom_range(1) == 0);
        end
        bus.i2c_wr_done = 1'b0;
        repeat (4) @(negedge clk);

        tot = 0;
        for (int i = 0; i < NREQ; i++) begin
            chk("rand_served", dut_done_cnt[i] > 0, 1);
            tot += dut_done_cnt[i];
        end
        chk("done_total", tot, m_done_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
